// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// States, opcodes, funct codes, ALU codes and datapath select values.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_controller_alu.sv
// ALU decoder: maps ALUOp and funct to ALUControl.
// Flags unknown funct codes; those still execute as add.
module mips_alu_decoder
  import mips_mc_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_ctrl_o,
  output logic       illegal_funct_o
);

  always_comb begin
    alu_ctrl_o      = ALU_ADD;
    illegal_funct_o = 1'b0;
    unique case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          F_ADD:   alu_ctrl_o = ALU_ADD;
          F_SUB:   alu_ctrl_o = ALU_SUB;
          F_AND:   alu_ctrl_o = ALU_AND;
          F_OR:    alu_ctrl_o = ALU_OR;
          F_SLT:   alu_ctrl_o = ALU_SLT;
          default: illegal_funct_o = 1'b1;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control FSM (Moore, Zero only feeds PCEn).
// Write enables are masked while rst_n is low.
module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       Illegal,
  output logic       Retire
);

  state_t  state_q, state_d;
  alu_op_t alu_op;
  logic    illegal_funct;
  logic    pc_write, branch;
  logic    mem_write, ir_write, reg_write;
  logic    illegal, retire;

  mips_alu_decoder u_alu_dec (
    .alu_op_i       (alu_op),
    .funct_i        (Funct),
    .alu_ctrl_o     (ALUControl),
    .illegal_funct_o(illegal_funct)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_FETCH;
    alu_op    = ALUOP_ADD;
    IorD      = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_B;
    PCSrc     = PC_ALU;
    pc_write  = 1'b0;
    branch    = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_write = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMMSH;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg  = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        IorD      = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
        illegal = illegal_funct;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst    = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = PC_ALUOUT;
        branch  = 1'b1;
        retire  = 1'b1;
      end
      S_ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        PCSrc    = PC_JUMP;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  assign MemWrite = mem_write & rst_n;
  assign IRWrite  = ir_write & rst_n;
  assign RegWrite = reg_write & rst_n;
  assign PCEn     = (pc_write | (branch & Zero)) & rst_n;
  assign Illegal  = illegal & rst_n;
  assign Retire   = retire & rst_n;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Randomized bench for mips_mc_controller against a per-instruction
// cycle-table reference model; second instance covers halt mode.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n, rst2_n;
  logic [5:0] Op, Funct;
  logic       Zero;

  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic       ALUSrcA, PCEn, Illegal, Retire;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUControl;

  logic       h_IorD, h_MemWrite, h_IRWrite, h_RegDst, h_MemtoReg;
  logic       h_RegWrite, h_ALUSrcA, h_PCEn, h_Illegal, h_Retire;
  logic [1:0] h_ALUSrcB, h_PCSrc;
  logic [2:0] h_ALUControl;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_mc_controller #(.ILLEGAL_HALT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .PCSrc(PCSrc), .PCEn(PCEn), .Illegal(Illegal), .Retire(Retire)
  );

  mips_mc_controller #(.ILLEGAL_HALT(1'b1)) dut_halt (
    .clk(clk), .rst_n(rst2_n), .Op(Op), .Funct(Funct), .Zero(Zero),
    .IorD(h_IorD), .MemWrite(h_MemWrite), .IRWrite(h_IRWrite),
    .RegDst(h_RegDst), .MemtoReg(h_MemtoReg), .RegWrite(h_RegWrite),
    .ALUSrcA(h_ALUSrcA), .ALUSrcB(h_ALUSrcB),
    .ALUControl(h_ALUControl), .PCSrc(h_PCSrc), .PCEn(h_PCEn),
    .Illegal(h_Illegal), .Retire(h_Retire)
  );

  wire [15:0] obs = {IorD, MemWrite, IRWrite, RegDst, MemtoReg,
    RegWrite, ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, Illegal,
    Retire};
  wire [15:0] obs_h = {h_IorD, h_MemWrite, h_IRWrite, h_RegDst,
    h_MemtoReg, h_RegWrite, h_ALUSrcA, h_ALUSrcB, h_ALUControl,
    h_PCSrc, h_PCEn, h_Illegal, h_Retire};
  wire [5:0] en = {MemWrite, IRWrite, RegWrite, PCEn, Illegal, Retire};
  wire [5:0] en_h = {h_MemWrite, h_IRWrite, h_RegWrite, h_PCEn,
    h_Illegal, h_Retire};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(
    input bit iord, input bit memw, input bit irw, input bit regdst,
    input bit m2r, input bit regw, input bit srca,
    input logic [1:0] srcb, input logic [2:0] aluc,
    input logic [1:0] pcsrc, input bit pcen, input bit ill,
    input bit ret);
    return {iord, memw, irw, regdst, m2r, regw, srca, srcb, aluc,
            pcsrc, pcen, ill, ret};
  endfunction

  function automatic bit legal_op(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                      6'b001000, 6'b000010};
  endfunction

  // Instruction length in cycles; illegal ops stop after decode.
  function automatic int ilen(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] rfunct(input logic [5:0] f);
    case (f)
      6'b100000: return 4'b0010;
      6'b100010: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b101010: return 4'b0111;
      default:   return 4'b1010;
    endcase
  endfunction

  function automatic logic [15:0] expv(input logic [5:0] op,
    input logic [5:0] f, input int k, input bit z);
    logic [3:0] r;
    r = rfunct(f);
    if (k == 0) return mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0,0);
    if (k == 1)
      return mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,!legal_op(op),0);
    case (op)
      6'b100011, 6'b101011: begin
        if (k == 2) return mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0);
        if (op == 6'b101011)
          return mk(1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0,1);
        if (k == 3) return mk(1,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0,0);
        return mk(0,0,0,0,1,1,0,2'b00,3'b010,2'b00,0,0,1);
      end
      6'b000000: begin
        if (k == 2)
          return mk(0,0,0,0,0,0,1,2'b00,r[2:0],2'b00,0,r[3],0);
        return mk(0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,0,1);
      end
      6'b000100: return mk(0,0,0,0,0,0,1,2'b00,3'b110,2'b01,z,0,1);
      6'b001000: begin
        if (k == 2) return mk(0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0,0);
        return mk(0,0,0,0,0,1,0,2'b00,3'b010,2'b00,0,0,1);
      end
      default: return mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b10,1,0,1);
    endcase
  endfunction

  // Entered #1 after the edge that put the DUT in FETCH; exits likewise.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                           input int id);
    for (int k = 0; k < ilen(op); k++) begin
      Op    = (k == 0) ? 6'($urandom) : op;
      Funct = (op == 6'b000000 && k == 2) ? f : 6'($urandom);
      Zero  = 1'($urandom);
      @(negedge clk);
      check($sformatf("i%0d op%b c%0d", id, op, k), 32'(obs),
            32'(expv(op, f, k, Zero)));
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] pick_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = 6'b100011;
      1: o = 6'b101011;
      2: o = 6'b000000;
      3: o = 6'b000100;
      4: o = 6'b001000;
      5: o = 6'b000010;
      default: begin
        o = 6'($urandom);
        while (legal_op(o)) o = 6'($urandom);
      end
    endcase
    return o;
  endfunction

  function automatic logic [5:0] pick_funct();
    logic [5:0] t [5];
    t = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    if ($urandom_range(0, 5) == 0) return 6'($urandom);
    return t[$urandom_range(0, 4)];
  endfunction

  logic [15:0] fetch_v, halt_v;

  initial begin
    fetch_v = mk(0,0,1,0,0,0,0,2'b01,3'b010,2'b00,1,0,0);
    halt_v  = mk(0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0,0);
    rst_n = 1'b0; rst2_n = 1'b0;
    Op = 6'b100011; Funct = '0; Zero = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("rst_en c%0d", c), 32'(en), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Directed sequence from the plan, then a random stream.
    run_instr(6'b100011, 6'b0, 0);
    run_instr(6'b000000, 6'b101010, 1);
    run_instr(6'b000000, 6'b100101, 2);
    run_instr(6'b000100, 6'b0, 3);
    run_instr(6'b000010, 6'b0, 4);
    run_instr(6'b101011, 6'b0, 5);
    run_instr(6'b111111, 6'b0, 6);
    for (int i = 0; i < 300; i++) begin
      logic [5:0] o, f;
      o = pick_op();
      f = pick_funct();
      run_instr(o, f, 100 + i);
    end
    // Reset in MEMRD of a lw abandons it.
    Op = 6'b100011;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_en", 32'(en), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_instr(6'b101011, 6'b0, 900);
    // Halting instance: illegal op parks until reset.
    rst2_n = 1'b1;
    Op = 6'($urandom);
    @(negedge clk);
    check("halt fetch", 32'(obs_h), 32'(fetch_v));
    @(posedge clk);
    #1 Op = 6'b111111;
    @(negedge clk);
    check("halt decode", 32'(obs_h),
          32'(mk(0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,1,0)));
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      Op = 6'($urandom); Funct = 6'($urandom); Zero = 1'($urandom);
      @(negedge clk);
      check($sformatf("halt c%0d", c), 32'(obs_h), 32'(halt_v));
    end
    @(posedge clk);
    #1 rst2_n = 1'b0;
    @(negedge clk);
    check("halt rst_en", 32'(en_h), 32'd0);
    @(posedge clk);
    #1 rst2_n = 1'b1;
    @(negedge clk);
    check("halt recover", 32'(obs_h), 32'(fetch_v));
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
